// File: rtl/kgp_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kgp_alu_pkg
//  Description : Shared definitions for the KGP-RISC execution units:
//                operation encodings of the iterative shift/multiply unit,
//                its controller state encoding and the datapath word width.
//  Revision    : 1.0  initial release
// ============================================================================
package kgp_alu_pkg;

    // Native datapath word width of the core.
    localparam int KGP_WORD_W = 32;

    // Operation encodings presented on the 'op' port.
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    // Controller states of the iterative unit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } shift_state_t;

endpackage : kgp_alu_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Purely combinational one-bit shifter. Produces the next
//                accumulator value for one iteration of SLL, SRL or SRA.
//                Any other encoding falls back to a left shift; the caller
//                never consumes the step output for such operations.
//  Ports       : i_opq  [1:0]        operation captured at acceptance
//                i_acc  [WIDTH-1:0]  current accumulator value
//                o_nxt  [WIDTH-1:0]  accumulator after one shift step
//  Revision    : 1.0  initial release
// ============================================================================
module shift_step
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = KGP_WORD_W
) (
    input  logic [1:0]       i_opq,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_nxt
);

    always_comb begin
        o_nxt = {i_acc[WIDTH-2:0], 1'b0};
        case (i_opq)
            OP_SRL:  o_nxt = {1'b0, i_acc[WIDTH-1:1]};
            // Arithmetic right shift replicates the sign bit.
            OP_SRA:  o_nxt = {i_acc[WIDTH-1], i_acc[WIDTH-1:1]};
            default: ;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shift_unit
//  Description : Multi-cycle shift / multiply execution unit. Shifts the
//                accumulator one bit position per clock under a
//                start/busy/done handshake, so the single-cycle ALU needs no
//                barrel shifter. Optional 32-iteration shift-add unsigned
//                multiply (low 32 product bits).
//  Config      : KGP_ITER_MUL_EN  defined  -> op 11 is an unsigned multiply
//                                 undefined-> op 11 behaves as SLL by 0
//  Ports       : clk    in   sole clock, rising edge
//                rst    in   synchronous active-high reset
//                start  in   request, ignored while busy
//                op     in   [1:0] 00 SLL, 01 SRL, 10 SRA, 11 MUL
//                a      in   [WIDTH-1:0] value to shift / multiplicand
//                b      in   [WIDTH-1:0] b[4:0] shift amount / multiplier
//                busy   out  high while iterating
//                done   out  one-cycle pulse when result is updated
//                result out  [WIDTH-1:0] last completed result (held)
//  Revision    : 1.0  initial release
// ============================================================================
module iter_shift_unit
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = KGP_WORD_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Shift amount field width inside 'b'.
    localparam int c_SHAMT_W = $clog2(WIDTH);

    // Controller encoding, taken from the shared state type.
    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_RUN  = RUN;
    localparam logic [1:0] c_ST_DONE = DONE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_opq;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_step;
    logic             w_accept;
    logic [CNT_W-1:0] w_shamt;

`ifdef KGP_ITER_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_sum;
`else
    // Upper multiplier bits have no consumer when multiply is absent.
    logic             w_unused_b;
    assign w_unused_b = ^b[WIDTH-1:c_SHAMT_W];
`endif

    // A request is taken whenever the unit is not iterating; this lets a
    // new operation start in the DONE cycle with no idle gap.
    assign w_accept = start && (r_state != c_ST_RUN);
    assign w_shamt  = CNT_W'(b[c_SHAMT_W-1:0]);

    // ------------------------------------------------------------------
    // One-bit shift datapath
    // ------------------------------------------------------------------
    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_opq (r_opq),
        .i_acc (r_acc),
        .o_nxt (w_step)
    );

`ifdef KGP_ITER_MUL_EN
    // Partial-product accumulation, modulo 2^WIDTH.
    assign w_sum = r_acc + r_mcand;
`endif

    // ------------------------------------------------------------------
    // Controller and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_opq    <= OP_SLL;
            r_result <= '0;
`ifdef KGP_ITER_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (r_cnt == '0) begin
                        r_result <= r_acc;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
`ifdef KGP_ITER_MUL_EN
                        if (r_opq == OP_MUL) begin
                            if (r_mplier[0]) begin
                                r_acc <= w_sum;
                            end
                            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        end else begin
                            r_acc <= w_step;
                        end
`else
                        r_acc <= w_step;
`endif
                    end
                end

                // IDLE and DONE both accept a new request.
                default: begin
                    if (w_accept) begin
                        r_state <= c_ST_RUN;
                        r_opq   <= op;
                        r_acc   <= a;
                        r_cnt   <= w_shamt;
`ifdef KGP_ITER_MUL_EN
                        if (op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_cnt    <= CNT_W'(WIDTH);
                        end
`else
                        // Without multiply hardware op 11 is a shift by 0,
                        // so the operand passes straight through.
                        if (op == OP_MUL) begin
                            r_cnt <= '0;
                        end
`endif
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: busy and done decode mutually exclusive states.
    // ------------------------------------------------------------------
    assign busy   = (r_state == c_ST_RUN);
    assign done   = (r_state == c_ST_DONE);
    assign result = r_result;

endmodule : iter_shift_unit
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_shift_unit
//  Description : Directed self-checking bench for iter_shift_unit. Expected
//                results and latencies are hand-computed constants.
//  Config      : KGP_ITER_MUL_EN selects the multiply expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iter_shift_unit;

    localparam logic [1:0] c_SLL = 2'b00;
    localparam logic [1:0] c_SRL = 2'b01;
    localparam logic [1:0] c_SRA = 2'b10;
    localparam logic [1:0] c_MUL = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec;
    int n_err;

    iter_shift_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally keep 'start' high (with different
    // operands) for 'hold' cycles while running, then wait for done and
    // check result, latency and handshake. Returns just after the done edge,
    // i.e. inside the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int lat;
        bit got;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);            // E0
        #1;
        check_vec({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        check_vec({tag, " done_after_accept"}, 32'(done), 32'd0);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k <= hold);
            op = o ^ 2'b01; a = ~av; b = bv ^ 32'h1;
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check_vec({tag, " done_timeout"}, 32'd0, 32'd1);
        end else begin
            check_vec({tag, " latency"}, 32'(lat), 32'(exp_lat));
            check_vec({tag, " result"}, result, exp_res);
            check_vec({tag, " busy_at_done"}, 32'(busy), 32'd0);
        end
        start = 1'b0;
    endtask

    int ndone;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = c_SLL;
        a     = '0;
        b     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset busy", 32'(busy), 32'd0);
        check_vec("reset done", 32'(done), 32'd0);
        check_vec("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // SLL by 31 (maximum amount)
        run_op("sll31", c_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32, 0);

        // Reset in the middle of a long SLL by 20
        @(negedge clk);
        op = c_SLL; a = 32'h0000_0001; b = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_vec("midrun_rst busy", 32'(busy), 32'd0);
        check_vec("midrun_rst done", 32'(done), 32'd0);
        check_vec("midrun_rst result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check_vec("midrun_rst stays_idle", 32'(ndone), 32'd0);

        // SRA vs SRL on a negative value
        run_op("sra4", c_SRA, 32'hF000_0000, 32'd4, 32'hFF00_0000, 5, 0);
        run_op("srl4", c_SRL, 32'hF000_0000, 32'd4, 32'h0F00_0000, 5, 0);

        // Zero amount: upper b bits set but b[4:0]=0
        run_op("zero_amt", c_SRL, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1, 0);

        // Start held during RUN with different operands is ignored
        run_op("ign_start", c_SLL, 32'h0000_0003, 32'd4, 32'h0000_0030, 5, 2);
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check_vec("ign_start no_second_op", 32'(ndone), 32'd0);

        // Back-to-back: second start driven in the first DONE cycle
        run_op("b2b_first", c_SLL, 32'h0000_0001, 32'd3, 32'h0000_0008, 4, 0);
        run_op("b2b_second", c_SRL, 32'h0000_0008, 32'd1, 32'h0000_0004, 2, 0);

`ifdef KGP_ITER_MUL_EN
        run_op("mul", c_MUL, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 33, 0);
        run_op("mul_wrap", c_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
`else
        run_op("mul_off", c_MUL, 32'h0001_0003, 32'h0001_0005, 32'h0001_0003, 1, 0);
`endif

        // Result held after completion
        repeat (3) @(posedge clk);
        #1;
`ifdef KGP_ITER_MUL_EN
        check_vec("result_hold", result, 32'h0000_0001);
`else
        check_vec("result_hold", result, 32'h0001_0003);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_iter_shift_unit
`default_nettype wire
